register_file_sb: RTL and testbench

Parametrised integer register file with multiple synchronous read ports, one write port, write-to-read bypass, hardwired-zero register 0 and a per-register busy scoreboard. It sits between the decode stage and the ALU/writeback path of the core. Decode uses the busy bits to detect read-after-write hazards, and writeback clears them.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 75 +++++++
 rtl/register_file_sb.sv | 109 ++++++++++
 tb/tb_register_file_sb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//
// Purpose: shared constants for the integer register file and its busy
// scoreboard. Holds the default geometry used by the core and the index of
// the hardwired-zero register.
//
// Contents:
//   XLEN_DEF   default data width of one register
//   NREGS_DEF  default number of architectural registers (power of 2, >= 2)
//   NREAD_DEF  default number of read ports (>= 1)
//   ZERO_REG   index of the register that always reads as zero
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

  // Register 0 is hardwired to zero: never written, never marked busy.
  localparam int ZERO_REG  = 0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Purpose: per-register busy (pending producer) tracking for the register
// file. Decode allocates a destination register, which marks it busy;
// writeback clears it. A registered population count of the busy vector is
// kept for the pipeline's occupancy bookkeeping.
//
// Ports:
//   clk         in   clock, all updates on the rising edge
//   rst_n       in   asynchronous active-low reset, clears every busy bit
//   we          in   writeback enable (clears busy[waddr])
//   waddr       in   writeback register index
//   alloc_en    in   allocate enable (sets busy[alloc_addr])
//   alloc_addr  in   register index being allocated
//   busy        out  current busy vector, one bit per register
//   busy_cnt    out  number of busy registers, registered
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(NREGS)-1:0]   waddr,
  input  logic                       alloc_en,
  input  logic [$clog2(NREGS)-1:0]   alloc_addr,
  output logic [NREGS-1:0]           busy,
  output logic [$clog2(NREGS):0]     busy_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    cnt_next;

  // Next busy vector. The clear from writeback is applied first and the set
  // from allocation second, so when both hit the same register in one cycle
  // the new producer wins and the register stays busy. Register 0 is
  // excluded from both, so its bit can never become 1.
  always_comb begin
    busy_next = busy;
    if (we && (waddr != ZERO_ADDR)) begin
      busy_next[waddr] = 1'b0;
    end
    if (alloc_en && (alloc_addr != ZERO_ADDR)) begin
      busy_next[alloc_addr] = 1'b1;
    end
  end

  // Population count of the post-update vector, so the registered count
  // always agrees with the busy bits that become visible after the edge.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + CW'(busy_next[i]);
    end
  end

  // Busy vector and its count share one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule : regfile_scoreboard

// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//
// Purpose: integer register file with NREAD registered read ports, one write
// port with write-to-read bypass, hardwired-zero register 0 and a busy
// scoreboard used by decode for read-after-write hazard detection.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   raddr       in   NREAD*AW read addresses, port i at [i*AW +: AW]
//   rdata       out  NREAD*XLEN registered read data, port i at [i*XLEN +: XLEN]
//   rbusy       out  NREAD registered busy flags, one per read port
//   we          in   writeback enable
//   waddr       in   writeback register index
//   wdata       in   writeback data
//   alloc_en    in   mark alloc_addr as pending
//   alloc_addr  in   register to mark pending
//   busy_cnt    out  registered number of busy registers
// ---------------------------------------------------------------------------
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = NREAD_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREAD*$clog2(NREGS)-1:0]   raddr,
  output logic [NREAD*XLEN-1:0]            rdata,
  output logic [NREAD-1:0]                 rbusy,
  input  logic                             we,
  input  logic [$clog2(NREGS)-1:0]         waddr,
  input  logic [XLEN-1:0]                  wdata,
  input  logic                             alloc_en,
  input  logic [$clog2(NREGS)-1:0]         alloc_addr,
  output logic [$clog2(NREGS):0]           busy_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;

  // Busy tracking lives in its own block; the read ports below only look at
  // the registered busy vector, so a same-cycle allocation is not visible
  // to the instruction that performs it.
  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  // Data array. Entry 0 is cleared on reset and never written afterwards,
  // so it holds zero permanently; the read muxes still force zero for it
  // so the port behaviour does not depend on that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  // One registered read port per generate iteration. Priority is zero
  // register, then the writeback bypass, then the array. A bypassed read
  // reports not-busy because the writeback in the same cycle retires the
  // pending producer (a same-cycle re-allocation is deliberately invisible
  // to the read, matching the order decode reads sources before its own
  // destination becomes pending).
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdata_q;
    logic            rbusy_q;

    assign ra = raddr[p*AW +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
        rbusy_q <= 1'b0;
      end else if (ra == ZERO_ADDR) begin
        rdata_q <= '0;
        rbusy_q <= 1'b0;
      end else if (we && (waddr == ra)) begin
        rdata_q <= wdata;
        rbusy_q <= 1'b0;
      end else begin
        rdata_q <= mem[ra];
        rbusy_q <= busy[ra];
      end
    end

    assign rdata[p*XLEN +: XLEN] = rdata_q;
    assign rbusy[p]              = rbusy_q;
  end : g_rd

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// ---------------------------------------------------------------------------
// tb_register_file_sb
//
// Purpose: directed self-checking bench for register_file_sb with the default
// geometry (32 x 32-bit, 2 read ports). Each step drives one cycle of inputs
// and then compares the registered outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_register_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0]      rbusy;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wdata;
  logic                  alloc_en;
  logic [AW-1:0]         alloc_addr;
  logic [AW:0]           busy_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  register_file_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_cnt   (busy_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle 1 time unit after the
  // edge so the registered outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                               input logic w_en, input logic [AW-1:0] w_a,
                               input logic [XLEN-1:0] w_d,
                               input logic a_en, input logic [AW-1:0] a_a);
    raddr      = {ra1, ra0};
    we         = w_en;
    waddr      = w_a;
    wdata      = w_d;
    alloc_en   = a_en;
    alloc_addr = a_a;
    @(posedge clk);
    #1;
  endtask

  // Convenience accessors for the two read ports.
  function automatic logic [XLEN-1:0] rd0();
    return rdata[XLEN-1:0];
  endfunction
  function automatic logic [XLEN-1:0] rd1();
    return rdata[2*XLEN-1:XLEN];
  endfunction

  initial begin
    rst_n      = 1'b0;
    raddr      = '0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;

    // Reset state
    #2;
    checkOutput("reset_rdata", 64'(rdata), 64'h0);
    checkOutput("reset_rbusy", 64'(rbusy), 64'h0);
    checkOutput("reset_cnt", 64'(busy_cnt), 64'h0);
    #10 rst_n = 1'b1;

    // Basic write then read of x5
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    checkOutput("write_cnt", 64'(busy_cnt), 64'h0);
    applyStimulus(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("read_x5_data", 64'(rd0()), 64'hDEADBEEF);
    checkOutput("read_x5_busy", 64'(rbusy[0]), 64'h0);

    // Bypass on both ports
    applyStimulus(5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    checkOutput("bypass_p0_data", 64'(rd0()), 64'h12345678);
    checkOutput("bypass_p1_data", 64'(rd1()), 64'h12345678);
    checkOutput("bypass_rbusy", 64'(rbusy), 64'h0);

    // Zero register: write and alloc to x0 are ignored
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    checkOutput("x0_bypass_data", 64'(rd0()), 64'h0);
    checkOutput("x0_cnt", 64'(busy_cnt), 64'h0);
    applyStimulus(5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x0_read_data", 64'(rd0()), 64'h0);
    checkOutput("x0_read_busy", 64'(rbusy[0]), 64'h0);
    checkOutput("x7_array_data", 64'(rd1()), 64'h12345678);

    // Scoreboard: alloc x3, same-cycle read does not see it
    applyStimulus(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    checkOutput("alloc_x3_cnt", 64'(busy_cnt), 64'h1);
    checkOutput("alloc_x3_samecyc_busy", 64'(rbusy[0]), 64'h0);
    applyStimulus(5'd3, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x3_busy_next", 64'(rbusy[0]), 64'h1);
    checkOutput("x3_data_next", 64'(rd0()), 64'h0);
    checkOutput("x5_p1_data", 64'(rd1()), 64'hDEADBEEF);

    // Writeback x3 clears busy
    applyStimulus(5'd3, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0);
    checkOutput("wb_x3_cnt", 64'(busy_cnt), 64'h0);
    checkOutput("wb_x3_bypass", 64'(rd0()), 64'hA5A5A5A5);
    applyStimulus(5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x3_after_wb_data", 64'(rd1()), 64'hA5A5A5A5);
    checkOutput("x3_after_wb_busy", 64'(rbusy[1]), 64'h0);

    // Collision: x9 busy, then same-cycle writeback and alloc of x9
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    checkOutput("alloc_x9_cnt", 64'(busy_cnt), 64'h1);
    applyStimulus(5'd9, 5'd0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd9);
    checkOutput("collide_cnt", 64'(busy_cnt), 64'h1);
    checkOutput("collide_bypass_data", 64'(rd0()), 64'hCAFEF00D);
    checkOutput("collide_bypass_busy", 64'(rbusy[0]), 64'h0);
    applyStimulus(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x9_after_data", 64'(rd1()), 64'hCAFEF00D);
    checkOutput("x9_after_busy", 64'(rbusy[1]), 64'h1);

    // Alloc x12 plus writeback to non-busy x20 in one cycle
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd20, 32'h00000011, 1'b1, 5'd12);
    checkOutput("two_busy_cnt", 64'(busy_cnt), 64'h2);
    applyStimulus(5'd20, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x20_data", 64'(rd0()), 64'h11);
    checkOutput("x20_busy", 64'(rbusy[0]), 64'h0);
    checkOutput("x12_busy", 64'(rbusy[1]), 64'h1);

    // Put non-zero values on the outputs, then reset mid-cycle with a
    // pending write and alloc that must be discarded.
    applyStimulus(5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("pre_reset_p0", 64'(rd0()), 64'hDEADBEEF);
    raddr      = {5'd9, 5'd5};
    we         = 1'b1;
    waddr      = 5'd5;
    wdata      = 32'h00000077;
    alloc_en   = 1'b1;
    alloc_addr = 5'd4;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_rdata", 64'(rdata), 64'h0);
    checkOutput("midreset_rbusy", 64'(rbusy), 64'h0);
    checkOutput("midreset_cnt", 64'(busy_cnt), 64'h0);
    @(negedge clk);
    raddr    = '0;
    we       = 1'b0;
    alloc_en = 1'b0;
    rst_n    = 1'b1;

    // After reset: x5 cleared, x9 no longer busy, x4 never allocated
    applyStimulus(5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("post_reset_x5", 64'(rd0()), 64'h0);
    checkOutput("post_reset_x9_data", 64'(rd1()), 64'h0);
    checkOutput("post_reset_rbusy", 64'(rbusy), 64'h0);
    checkOutput("post_reset_cnt", 64'(busy_cnt), 64'h0);
    applyStimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("post_reset_x4_busy", 64'(rbusy[0]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_register_file_sb
